superscalar_issue_ctrl: RTL and testbench

//  N-lane in-order bundle issue controller; the parametrised successor to the fixed two-lane controller pair.

---
 rtl/superscalar_pkg.sv | 58 +++++
 rtl/issue_hazard_unit.sv | 66 ++++++
 rtl/superscalar_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_superscalar_issue_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/superscalar_pkg.sv
// Shared opcode constants, FSM state encoding and opcode-class helpers for the
// bundle issue controller.
package superscalar_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
            default:                                                writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: reads_rs1 = 1'b1;
            default:                                           reads_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
            default:                   reads_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: is_mem = 1'b1;
            default:           is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        case (op)
            OP_BRANCH, OP_JAL, OP_JALR: is_ctrl = 1'b1;
            default:                    is_ctrl = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_hazard_unit.sv
// Combinational selection of the largest hazard-free contiguous run of pending
// lanes, starting at the lowest pending lane.
module issue_hazard_unit
    import superscalar_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]   i_pending,
    input  logic [LANES*7-1:0] i_op,
    input  logic [LANES*5-1:0] i_rd,
    input  logic [LANES*5-1:0] i_rs1,
    input  logic [LANES*5-1:0] i_rs2,
    output logic [LANES-1:0]   o_issue_mask
);

    logic [LANES-1:0] w_mask;
    logic             w_started;
    logic             w_stop;
    logic             w_hit;

    // Does earlier lane j block later lane i from joining the same pass?
    function automatic logic pair_hazard(input logic [6:0] op_j, input logic [4:0] rd_j,
                                         input logic [6:0] op_i, input logic [4:0] rd_i,
                                         input logic [4:0] rs1_i, input logic [4:0] rs2_i);
        logic w_j_dst;
        w_j_dst     = writes_rd(op_j) && (rd_j != 5'd0);
        pair_hazard = (w_j_dst && reads_rs1(op_i) && (rs1_i == rd_j))
                   || (w_j_dst && reads_rs2(op_i) && (rs2_i == rd_j))
                   || (w_j_dst && writes_rd(op_i) && (rd_i == rd_j))
                   || (is_mem(op_j) && is_mem(op_i))
                   || is_ctrl(op_j);
    endfunction

    // Grow the run lane by lane; the first blocked or non-pending lane ends it.
    always_comb begin
        w_mask    = {LANES{1'b0}};
        w_started = 1'b0;
        w_stop    = 1'b0;
        w_hit     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_hit = 1'b0;
            for (int j = 0; j < LANES; j++) begin
                if ((j < i) && w_mask[j] &&
                    pair_hazard(i_op[7*j +: 7], i_rd[5*j +: 5], i_op[7*i +: 7],
                                i_rd[5*i +: 5], i_rs1[5*i +: 5], i_rs2[5*i +: 5])) begin
                    w_hit = 1'b1;
                end else begin
                    w_hit = w_hit;
                end
            end
            if (!i_pending[i]) begin
                w_stop = w_stop | w_started;
            end else if (!w_started) begin
                w_mask[i] = 1'b1;
                w_started = 1'b1;
            end else if (w_stop || w_hit) begin
                w_stop = 1'b1;
            end else begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign o_issue_mask = w_mask;

endmodule

// File: rtl/superscalar_issue_ctrl.sv
// N-lane in-order bundle issue controller: issues the hazard-free prefix of a
// bundle per pass and replays the remaining lanes until the bundle retires.
module superscalar_issue_ctrl
    import superscalar_pkg::*;
#(
    parameter  int LANES = 2,
    parameter  int CNT_W = 16,
    localparam int RL_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [LANES*7-1:0] op,
    input  logic [LANES*5-1:0] rd,
    input  logic [LANES*5-1:0] rs1,
    input  logic [LANES*5-1:0] rs2,
    input  logic [LANES-1:0]   branch_taken,
    input  logic               mem_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_redirect,
    output logic [RL_W-1:0]    redirect_lane,
    output logic [LANES-1:0]   issue_mask,
    output logic [LANES-1:0]   reg_write,
    output logic [LANES-1:0]   mem_write,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   replay_cnt
);

    state_t            r_state;
    state_t            w_next;
    logic [LANES-1:0]  r_pending;
    logic [LANES-1:0]  r_issue;
    logic              r_taken;
    logic [RL_W-1:0]   r_tlane;
    logic [CNT_W-1:0]  r_replay;

    logic [LANES-1:0]  w_issue;
    logic [LANES-1:0]  w_remain;
    logic [LANES-1:0]  w_wr_lanes;
    logic [LANES-1:0]  w_st_lanes;
    logic [LANES-1:0]  w_mem_lanes;
    logic [LANES-1:0]  w_take_lanes;
    logic [RL_W-1:0]   w_take_idx;

    issue_hazard_unit #(.LANES(LANES)) u_hazard (
        .i_pending    (r_pending),
        .i_op         (op),
        .i_rd         (rd),
        .i_rs1        (rs1),
        .i_rs2        (rs2),
        .o_issue_mask (w_issue)
    );

    assign w_remain = r_pending & ~r_issue;

    // Per-lane opcode classes and the (single) redirecting lane of this pass.
    always_comb begin
        w_wr_lanes   = {LANES{1'b0}};
        w_st_lanes   = {LANES{1'b0}};
        w_mem_lanes  = {LANES{1'b0}};
        w_take_lanes = {LANES{1'b0}};
        w_take_idx   = {RL_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_wr_lanes[i]   = writes_rd(op[7*i +: 7]);
            w_st_lanes[i]   = (op[7*i +: 7] == OP_STORE);
            w_mem_lanes[i]  = is_mem(op[7*i +: 7]);
            w_take_lanes[i] = r_issue[i] && (((op[7*i +: 7] == OP_BRANCH) && branch_taken[i])
                                           || (op[7*i +: 7] == OP_JAL)
                                           || (op[7*i +: 7] == OP_JALR));
            if (w_take_lanes[i]) begin
                w_take_idx = RL_W'(i);
            end else begin
                w_take_idx = w_take_idx;
            end
        end
    end

    // Next-state and strobe decode; strobes follow the registered state so reset drops them at once.
    always_comb begin
        w_next        = r_state;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_redirect   = 1'b0;
        redirect_lane = {RL_W{1'b0}};
        reg_write     = {LANES{1'b0}};
        mem_write     = {LANES{1'b0}};
        case (r_state)
            FETCH: begin
                if (fetch_valid && reset) begin
                    ir_write = 1'b1;
                    w_next   = DECODE;
                end else begin
                    w_next = FETCH;
                end
            end
            DECODE: w_next = EXEC;
            EXEC: begin
                if (|(r_issue & w_mem_lanes)) begin
                    w_next = MEM;
                end else begin
                    w_next = WB;
                end
            end
            MEM: begin
                mem_write = r_issue & w_st_lanes;
                if (mem_ready) begin
                    w_next = WB;
                end else begin
                    w_next = MEM;
                end
            end
            WB: begin
                reg_write = r_issue & w_wr_lanes;
                if (r_taken) begin
                    pc_write      = 1'b1;
                    pc_redirect   = 1'b1;
                    redirect_lane = r_tlane;
                    w_next        = FETCH;
                end else if (w_remain == {LANES{1'b0}}) begin
                    pc_write = 1'b1;
                    w_next   = FETCH;
                end else begin
                    w_next = DECODE;
                end
            end
            default: w_next = FETCH;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Bundle bookkeeping: pending lanes, issued pass, redirect capture, replay counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= {LANES{1'b0}};
            r_issue   <= {LANES{1'b0}};
            r_taken   <= 1'b0;
            r_tlane   <= {RL_W{1'b0}};
            r_replay  <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                FETCH: begin
                    if (fetch_valid) begin
                        r_pending <= {LANES{1'b1}};
                    end
                end
                DECODE: begin
                    r_issue <= w_issue;
                    if ((w_issue != r_pending) && (r_replay != {CNT_W{1'b1}})) begin
                        r_replay <= r_replay + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                EXEC: begin
                    r_taken <= |w_take_lanes;
                    r_tlane <= w_take_idx;
                end
                WB: begin
                    if (r_taken || (w_remain == {LANES{1'b0}})) begin
                        r_pending <= {LANES{1'b0}};
                        r_issue   <= {LANES{1'b0}};
                        r_taken   <= 1'b0;
                    end else begin
                        r_pending <= w_remain;
                    end
                end
                default: begin
                    r_pending <= r_pending;
                end
            endcase
        end
    end

    assign issue_mask = r_issue;
    assign state      = r_state;
    assign replay_cnt = r_replay;

endmodule

// File: tb/tb_superscalar_issue_ctrl.sv
// Bench for superscalar_issue_ctrl (LANES=4, CNT_W=2): directed bundles plus
// random bundles checked against a lane-list reference of the issue rules.
module tb_superscalar_issue_ctrl;

    localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
    localparam logic [6:0] JAL = 7'h6f, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;
    localparam logic [6:0] NOP = 7'h00, UNK = 7'h7f;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [27:0] op;
    logic [19:0] rd, rs1, rs2;
    logic [3:0]  bt;
    logic        mem_ready;
    logic        ir_write, pc_write, pc_redirect;
    logic [1:0]  redirect_lane;
    logic [3:0]  issue_mask, reg_write, mem_write;
    logic [2:0]  state;
    logic [1:0]  replay_cnt;

    logic [6:0]  b_op  [4];
    logic [4:0]  b_rd  [4];
    logic [4:0]  b_rs1 [4];
    logic [4:0]  b_rs2 [4];

    int n_vec = 0;
    int n_err = 0;
    int exp_replay = 0;

    superscalar_issue_ctrl #(.LANES(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .op(op), .rd(rd),
        .rs1(rs1), .rs2(rs2), .branch_taken(bt), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_redirect(pc_redirect),
        .redirect_lane(redirect_lane), .issue_mask(issue_mask), .reg_write(reg_write),
        .mem_write(mem_write), .state(state), .replay_cnt(replay_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic irw,
                           input logic pcw, input logic pcr, input logic [3:0] rw,
                           input logic [3:0] mw);
        chk({tag, ".state"}, state, st);
        chk({tag, ".ir_write"}, ir_write, irw);
        chk({tag, ".pc_write"}, pc_write, pcw);
        chk({tag, ".pc_redirect"}, pc_redirect, pcr);
        chk({tag, ".reg_write"}, reg_write, rw);
        chk({tag, ".mem_write"}, mem_write, mw);
    endtask

    task automatic set_lane(input int i, input logic [6:0] o, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2);
        b_op[i] = o; b_rd[i] = d; b_rs1[i] = s1; b_rs2[i] = s2;
        op[7*i +: 7] = o; rd[5*i +: 5] = d; rs1[5*i +: 5] = s1; rs2[5*i +: 5] = s2;
    endtask

    function automatic bit m_wr(input logic [6:0] o);
        return o inside {R, I, LD, JAL, JALR, LUI, AUIPC};
    endfunction
    function automatic bit m_r1(input logic [6:0] o);
        return o inside {R, I, LD, ST, BR, JALR};
    endfunction
    function automatic bit m_r2(input logic [6:0] o);
        return o inside {R, ST, BR};
    endfunction
    function automatic bit m_mem(input logic [6:0] o);
        return o inside {LD, ST};
    endfunction
    function automatic bit m_ctl(input logic [6:0] o);
        return o inside {BR, JAL, JALR};
    endfunction

    // Reference: accept lanes in order from the lowest pending one, each checked against every accepted lane.
    function automatic logic [3:0] ref_mask(input logic [3:0] pend);
        int acc[$];
        logic [3:0] m;
        int first;
        bit ok;
        m = 4'b0000;
        first = 4;
        for (int i = 3; i >= 0; i--) if (pend[i]) first = i;
        for (int i = first; i < 4; i++) begin
            ok = pend[i];
            foreach (acc[k]) begin
                int j;
                j = acc[k];
                if (m_wr(b_op[j]) && b_rd[j] != 5'd0 &&
                    ((m_r1(b_op[i]) && b_rs1[i] == b_rd[j]) || (m_r2(b_op[i]) && b_rs2[i] == b_rd[j])))
                    ok = 0;
                if (m_wr(b_op[j]) && m_wr(b_op[i]) && b_rd[j] != 5'd0 && b_rd[i] == b_rd[j]) ok = 0;
                if (m_mem(b_op[j]) && m_mem(b_op[i])) ok = 0;
                if (m_ctl(b_op[j])) ok = 0;
            end
            if (!ok) break;
            acc.push_back(i);
            m[i] = 1'b1;
        end
        return m;
    endfunction

    // Drive one bundle from FETCH to retirement; mw<0 picks a random MEM wait per pass.
    task automatic run_bundle(input int mw);
        logic [3:0] pend, pend_n, m, wmask, smask;
        int idle, w, tl;
        bit taken, anymem;
        idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) begin
            @(negedge clk); fetch_valid = 1'b0; #1;
            chk_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        end
        @(negedge clk); fetch_valid = 1'b1; #1;
        chk_out("fetch", 3'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        @(negedge clk); fetch_valid = 1'b0;
        pend = 4'hF;
        while (pend != 4'h0) begin
            #1;
            chk_out("decode", 3'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
            m = ref_mask(pend);
            if (m != pend && exp_replay < 3) exp_replay++;
            wmask = 4'b0000; smask = 4'b0000; anymem = 0; taken = 0; tl = 0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    if (m_wr(b_op[i])) wmask[i] = 1'b1;
                    if (b_op[i] == ST) smask[i] = 1'b1;
                    if (m_mem(b_op[i])) anymem = 1;
                    if (b_op[i] == JAL || b_op[i] == JALR || (b_op[i] == BR && bt[i])) begin
                        taken = 1; tl = i;
                    end
                end
            end
            @(negedge clk); #1;
            chk_out("exec", 3'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
            chk("exec.issue_mask", issue_mask, m);
            if (anymem) begin
                w = (mw < 0) ? $urandom_range(0, 3) : mw;
                for (int k = 0; k <= w; k++) begin
                    @(negedge clk); mem_ready = (k == w); #1;
                    chk_out("mem", 3'd3, 1'b0, 1'b0, 1'b0, 4'b0000, smask);
                    chk("mem.issue_mask", issue_mask, m);
                end
            end
            @(negedge clk); mem_ready = 1'b0; #1;
            pend_n = taken ? 4'h0 : (pend & ~m);
            chk_out("wb", 3'd4, 1'b0, pend_n == 4'h0, taken, wmask, 4'b0000);
            chk("wb.issue_mask", issue_mask, m);
            chk("wb.replay_cnt", replay_cnt, exp_replay);
            if (taken) chk("wb.redirect_lane", redirect_lane, tl);
            pend = pend_n;
            if (pend != 4'h0) @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] optab [11];
        optab = '{R, I, LD, ST, BR, JAL, JALR, LUI, AUIPC, NOP, UNK};
        reset = 1'b0; fetch_valid = 1'b0; mem_ready = 1'b0; bt = 4'b0000;
        op = 28'd0; rd = 20'd0; rs1 = 20'd0; rs2 = 20'd0;
        for (int i = 0; i < 4; i++) set_lane(i, NOP, 5'd0, 5'd0, 5'd0);
        #1;
        chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        chk("reset.issue_mask", issue_mask, 4'b0000);
        chk("reset.replay_cnt", replay_cnt, 2'd0);
        @(negedge clk); reset = 1'b1;

        // Independent adds: single pass.
        set_lane(0, R, 5'd1, 5'd2, 5'd3); set_lane(1, R, 5'd2, 5'd4, 5'd5);
        run_bundle(0);
        // RAW lane0 -> lane1.
        set_lane(0, R, 5'd1, 5'd2, 5'd3); set_lane(1, R, 5'd4, 5'd1, 5'd5);
        run_bundle(0);
        // Two loads share the memory port; 4 MEM cycles each.
        set_lane(0, LD, 5'd1, 5'd2, 5'd0); set_lane(1, LD, 5'd2, 5'd3, 5'd0);
        run_bundle(3);
        // Taken branch in lane 0 squashes lane 1.
        set_lane(0, BR, 5'd0, 5'd1, 5'd2); set_lane(1, R, 5'd5, 5'd6, 5'd7);
        bt = 4'b0001;
        run_bundle(0);
        bt = 4'b0000;

        // Store in lane 1, reset during the second MEM cycle.
        set_lane(0, NOP, 5'd0, 5'd0, 5'd0); set_lane(1, ST, 5'd0, 5'd1, 5'd2);
        @(negedge clk); fetch_valid = 1'b1; #1;
        chk_out("rst.fetch", 3'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        @(negedge clk); fetch_valid = 1'b0;
        @(negedge clk); #1;
        chk("rst.exec.state", state, 3'd2);
        @(negedge clk); #1;
        chk_out("rst.mem1", 3'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010);
        @(negedge clk); #1;
        chk_out("rst.mem2", 3'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010);
        #1 reset = 1'b0; #1;
        chk_out("rst.async", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        chk("rst.async.issue_mask", issue_mask, 4'b0000);
        chk("rst.async.replay_cnt", replay_cnt, 2'd0);
        exp_replay = 0;
        @(negedge clk); reset = 1'b1; #1;
        chk_out("rst.release", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

        // RAW between lanes 2 and 3, four times: counter saturates at 3.
        set_lane(0, R, 5'd1, 5'd0, 5'd0); set_lane(1, R, 5'd2, 5'd0, 5'd0);
        set_lane(2, R, 5'd3, 5'd0, 5'd0); set_lane(3, R, 5'd4, 5'd3, 5'd0);
        for (int n = 0; n < 4; n++) run_bundle(0);
        chk("sat.replay_cnt", replay_cnt, 2'd3);

        // Random bundles with a small register window to provoke hazards.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 4; i++)
                set_lane(i, optab[$urandom_range(0, 10)], 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            bt = 4'($urandom_range(0, 15));
            run_bundle(-1);
        end
        @(negedge clk); #1;
        chk_out("final", 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
